// File: rtl/store_aligner_pkg.sv
// rtl/store_aligner_pkg.sv - store op codes, byte-enable constants and the store packing helper
package store_aligner_pkg;

  localparam logic [7:0] STORE_WORD = 8'h31;
  localparam logic [7:0] STORE_HALF = 8'h32;
  localparam logic [7:0] STORE_BYTE = 8'h33;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef struct packed {
    logic        ok;
    logic [31:0] wdata;
    logic [3:0]  be;
  } pack_t;

  // Narrow a GPR value to its store width; lanes are replicated so the
  // byte enables alone select which bytes memory actually writes.
  function automatic pack_t pack_store(input logic [7:0]  op,
                                       input logic [1:0]  a,
                                       input logic [31:0] d);
    pack_t p;
    p.ok    = 1'b1;
    p.wdata = d;
    p.be    = BE_WORD;
    case (op)
      STORE_WORD: begin
        p.wdata = d;
        p.be    = BE_WORD;
      end
      STORE_HALF: begin
        p.wdata = {2{d[15:0]}};
        p.be    = a[1] ? BE_HALF_HI : BE_HALF_LO;
      end
      STORE_BYTE: begin
        p.wdata = {4{d[7:0]}};
        p.be    = 4'b0001 << a;
      end
      default: p.ok = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/store_aligner_if.sv
// rtl/store_aligner_if.sv - producer-side request and data-memory write port bundle
interface store_aligner_if #(parameter int ADDR_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        StoreOp;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byteen;
  logic              st_exc;
  logic [ADDR_W-1:0] exc_addr;

  modport slave (
    input  in_valid, StoreOp, in_addr, in_data, mem_ready,
    output in_ready, mem_valid, mem_addr, mem_wdata, mem_byteen, st_exc, exc_addr
  );

  modport master (
    output in_valid, StoreOp, in_addr, in_data, mem_ready,
    input  in_ready, mem_valid, mem_addr, mem_wdata, mem_byteen, st_exc, exc_addr
  );
endinterface

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - DEPTH-entry synchronous FIFO with flush and full/empty flags
module store_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 68
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Invalid head reads as zero so the memory port never shows stale data.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointers/count; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observable while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !reset) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/store_aligner.sv
// rtl/store_aligner.sv - sw/sh/sb packing into a store FIFO; STORE_ALIGN_EXC_EN adds misaligned-store exceptions
module store_aligner
  import store_aligner_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  store_aligner_if.slave  bus
);
  localparam int ENT_W = ADDR_W + 36;

  pack_t             pk;
  logic              misalign, hs, push, pop, full, empty;
  logic [ENT_W-1:0]  din, dout;

  assign pk = pack_store(bus.StoreOp, bus.in_addr[1:0], bus.in_data);

`ifdef STORE_ALIGN_EXC_EN
  assign misalign = ((bus.StoreOp == STORE_WORD) && (bus.in_addr[1:0] != 2'b00)) ||
                    ((bus.StoreOp == STORE_HALF) && bus.in_addr[0]);
`else
  assign misalign = 1'b0;
`endif

  // Unknown ops and faulting stores complete the handshake but are dropped.
  assign hs   = bus.in_valid && bus.in_ready;
  assign push = hs && pk.ok && !misalign;
  assign pop  = bus.mem_valid && bus.mem_ready;
  assign din  = {bus.in_addr[ADDR_W-1:2], 2'b00, pk.wdata, pk.be};

  store_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (dout),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.in_ready  = !full;
  assign bus.mem_valid = !empty;
  assign {bus.mem_addr, bus.mem_wdata, bus.mem_byteen} = dout;

`ifdef STORE_ALIGN_EXC_EN
  logic              st_exc_q, st_exc_d;
  logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;

  // A flushed store never raises; the last faulting address survives flushes.
  always_comb begin
    st_exc_d   = hs && misalign && !flush;
    exc_addr_d = st_exc_d ? bus.in_addr : exc_addr_q;
  end

  // Exception pulse and faulting-address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_exc_q   <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      st_exc_q   <= st_exc_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign bus.st_exc   = st_exc_q;
  assign bus.exc_addr = exc_addr_q;
`else
  assign bus.st_exc   = 1'b0;
  assign bus.exc_addr = '0;
`endif
endmodule

// File: doc/store_aligner.md
Name: store_aligner

Overview:
- MEM-stage store path: the reverse of immediate extension; it narrows a 32-bit GPR value to word/half/byte for sw/sh/sb.
- Produces a word-aligned address, replicated write data and 4-bit byte enables.
- Buffers the packed stores in a small FIFO, so data-memory back-pressure does not stall the producer immediately.
- Sits between the EX/MEM pipeline register and the data-memory write port.

Parameters:
- DEPTH, 2, number of FIFO entries (power of two, ≥2).
- ADDR_W, 32, byte-address width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- flush  input  1  synchronous pipeline flush; clears FIFO
- in_valid  input  1  store request present
- in_ready  output  1  FIFO can accept (count < DEPTH)
- StoreOp  input  8  `storeWord / `storeHalf / `storeByte
- in_addr  input  ADDR_W  byte address
- in_data  input  32  rt value
- mem_valid  output  1  head entry valid
- mem_ready  input  1  memory accepts head
- mem_addr  output  ADDR_W  {in_addr[ADDR_W-1:2],2'b00} of head
- mem_wdata  output  32  packed data of head
- mem_byteen  output  4  byte enables of head
- st_exc  output  1  misaligned-store pulse (feature only)
- exc_addr  output  ADDR_W  faulting byte address (feature only)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high, named reset.
- Reset values:
  - count=0, mem_valid=0, mem_addr/mem_wdata/mem_byteen=0.
  - st_exc=0, exc_addr=0.
  - in_ready=1 in the cycle after reset.
- Packing (combinational, before enqueue), with a = in_addr[1:0]:
  - sw: wdata=in_data, byteen=4'b1111.
  - sh: wdata={2{in_data[15:0]}}, byteen = a[1] ? 4'b1100 : 4'b0011.
  - sb: wdata={4{in_data[7:0]}}, byteen = 4'b0001 << a.
  - Any other StoreOp: handshake completes and nothing is enqueued (bubble).
- Push: fires when in_valid && in_ready. in_ready = (count != DEPTH); it does not depend on mem_ready in the same cycle, so there is no pass-through when full.
- Pop: fires when mem_valid && mem_ready. mem_valid = (count != 0). Head outputs are stable while mem_valid && !mem_ready.
- Latency: a push into an empty FIFO appears on the mem_* outputs on the next clock edge.
- Simultaneous push and pop: count unchanged; wr_ptr and rd_ptr both advance.
- Pointers: wrap modulo DEPTH. Full when count==DEPTH; empty when count==0.
- Priority: reset > flush > push/pop.
  - flush clears count and both pointers that edge; any push in the flush cycle is discarded.
  - Reset or flush mid-transfer drops entries that have not been popped.
- mem_wdata/mem_byteen carry no X: unused lanes hold the replicated values defined above.

Optional Feature:
- Macro: STORE_ALIGN_EXC_EN.
- Defined:
  - sw with a!=0, or sh with a[0]!=0, is accepted on the handshake but not enqueued.
  - st_exc pulses high for exactly one cycle on the following edge.
  - exc_addr latches in_addr and holds until the next exception or reset.
  - flush does not clear exc_addr.
- Undefined:
  - Misalignment is ignored: sw uses the aligned word; sh uses a[1] only.
  - st_exc is tied 0 and exc_addr is tied 0.

Decomposition:
- constants.v gains `storeWord, `storeHalf, `storeByte (8-bit codes, same space as the other op codes) and `BE_WORD/`BE_HALF_LO/`BE_HALF_HI.
- One natural sub-module, store_fifo: parameterised DEPTH×(ADDR_W+36) synchronous FIFO with count/full/empty.
- store_aligner instantiates store_fifo and keeps packing plus exception logic at the top level.

Test Plan:
- sb, addr=0x0000_1003, data=0x1234_56AB, mem_ready=1 → next cycle mem_valid=1, mem_addr=0x1000, wdata=0xABABABAB, byteen=4'b1000.
- sh, addr=0x2002, data=0xDEAD_BEEF → wdata=0xBEEFBEEF, byteen=4'b1100. Then sw, addr=0x2004 → byteen=4'b1111, wdata unchanged.
- Hold mem_ready=0 and push 3 stores → in_ready=0 after 2 pushes and the third is held. Release mem_ready → entries pop in order and in_ready returns to 1 after the first pop.
- count=1 with push and pop in the same cycle for 10 cycles → mem_valid stays 1, data stream in order, no loss.
- count=2, assert flush together with in_valid → next cycle mem_valid=0, count=0, and the flushed-cycle store is absent. Repeat with reset → same, and st_exc=0.
- STORE_ALIGN_EXC_EN defined: sw at 0x3001 → nothing enqueued, st_exc=1 for one cycle, exc_addr=0x3001. Undefined: mem_addr=0x3000, byteen=4'b1111, st_exc=0.
